fp_div_initiator: RTL and testbench

FP_DIV_INITIATOR -- requirements
Module: fp_div_initiator

---
 rtl/fp_div_initiator.sv | 251 +++++++++++++++++++++++++
 tb/tb_fp_div_initiator.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_initiator.sv
// ---------------------------------------------------------------------------
// fp_div_initiator
//
// Runs one IEEE-754 single-precision division job at a time against an
// external divider that uses stb/ack handshakes. A job (dividend, divisor) is
// accepted, operand A and then operand B are sent to the divider, and the
// result is collected, classified and presented on the result port. If the
// divider does not return a result within TIMEOUT cycles, the divider gets a
// one-cycle reset pulse and a quiet NaN is returned with the timeout flag set.
//
// Parameters
//   TIMEOUT      maximum number of WAIT_Z cycles before the job is aborted
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous, active-high reset
//   job_a/job_b  dividend / divisor;  job_stb in, job_ack out
//   div_a        operand A to divider; div_a_stb out, div_a_ack in
//   div_b        operand B to divider; div_b_stb out, div_b_ack in
//   div_z        result from divider;  div_z_stb in,  div_z_ack out
//   div_rst      one-cycle reset pulse to the divider on timeout
//   res_z        result word
//   res_flags    {timeout, nan, inf, zero}; res_stb out, res_ack in
//   ops_done     results delivered, wraps at 16 bits
//   ops_timeout  timeouts seen, saturates at 255
//
// Every output is a flop. The FSM is split into a register process, a
// next-state process and an output process; the output process computes the
// next value of each output flop so nothing combinational reaches a port.
// ---------------------------------------------------------------------------
module fp_div_initiator #(
  parameter int TIMEOUT = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] job_a,
  input  logic [31:0] job_b,
  input  logic        job_stb,
  output logic        job_ack,
  output logic [31:0] div_a,
  output logic        div_a_stb,
  input  logic        div_a_ack,
  output logic [31:0] div_b,
  output logic        div_b_stb,
  input  logic        div_b_ack,
  input  logic [31:0] div_z,
  input  logic        div_z_stb,
  output logic        div_z_ack,
  output logic        div_rst,
  output logic [31:0] res_z,
  output logic [3:0]  res_flags,
  output logic        res_stb,
  input  logic        res_ack,
  output logic [15:0] ops_done,
  output logic [7:0]  ops_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND_A  = 3'd1,
    SEND_B  = 3'd2,
    WAIT_Z  = 3'd3,
    PUT_RES = 3'd4
  } state_t;

  state_t state, state_d;

  logic [CW-1:0] wait_cnt, wait_cnt_d;

  logic        job_ack_d;
  logic [31:0] div_a_d;
  logic        div_a_stb_d;
  logic [31:0] div_b_d;
  logic        div_b_stb_d;
  logic        div_z_ack_d;
  logic        div_rst_d;
  logic [31:0] res_z_d;
  logic [3:0]  res_flags_d;
  logic        res_stb_d;
  logic [15:0] ops_done_d;
  logic [7:0]  ops_timeout_d;

  // Handshake completions. Each ack/stb driven here is only ever high in its
  // own state, so div_z_stb outside WAIT_Z can never complete a transfer.
  logic job_xfer, a_xfer, b_xfer, z_xfer, res_xfer;
  logic timeout_hit;

  assign job_xfer = job_stb   & job_ack;
  assign a_xfer   = div_a_stb & div_a_ack;
  assign b_xfer   = div_b_stb & div_b_ack;
  assign z_xfer   = div_z_stb & div_z_ack;
  assign res_xfer = res_stb   & res_ack;

  // The counter holds the number of WAIT_Z cycles already spent; the edge
  // that would take it to TIMEOUT is the abort edge. A result arriving on
  // that same edge takes priority.
  assign timeout_hit = (state == WAIT_Z) && !z_xfer &&
                       (wait_cnt == CW'(TIMEOUT - 1));

  // {timeout, nan, inf, zero}; a returned result never carries timeout.
  function automatic logic [3:0] classify(input logic [31:0] z);
    logic       exp_max;
    logic       exp_zero;
    logic       mant_nz;
    exp_max  = (z[30:23] == 8'hFF);
    exp_zero = (z[30:23] == 8'h00);
    mant_nz  = |z[22:0];
    return {1'b0, exp_max & mant_nz, exp_max & ~mant_nz, exp_zero & ~mant_nz};
  endfunction

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values of the others, independent of ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      job_ack     <= 1'b0;
      div_a       <= '0;
      div_a_stb   <= 1'b0;
      div_b       <= '0;
      div_b_stb   <= 1'b0;
      div_z_ack   <= 1'b0;
      div_rst     <= 1'b0;
      res_z       <= '0;
      res_flags   <= '0;
      res_stb     <= 1'b0;
      ops_done    <= '0;
      ops_timeout <= '0;
    end else begin
      state       <= state_d;
      wait_cnt    <= wait_cnt_d;
      job_ack     <= job_ack_d;
      div_a       <= div_a_d;
      div_a_stb   <= div_a_stb_d;
      div_b       <= div_b_d;
      div_b_stb   <= div_b_stb_d;
      div_z_ack   <= div_z_ack_d;
      div_rst     <= div_rst_d;
      res_z       <= res_z_d;
      res_flags   <= res_flags_d;
      res_stb     <= res_stb_d;
      ops_done    <= ops_done_d;
      ops_timeout <= ops_timeout_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: the default assignment at the top keeps every path assigned, so no
  // latch is inferred when a case branch does not change the state.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (job_xfer)                state_d = SEND_A;
      SEND_A:  if (a_xfer)                  state_d = SEND_B;
      SEND_B:  if (b_xfer)                  state_d = WAIT_Z;
      WAIT_Z:  if (z_xfer || timeout_hit)   state_d = PUT_RES;
      PUT_RES: if (res_xfer)                state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic: next value of every output flop
  // -------------------------------------------------------------------------
  always_comb begin
    wait_cnt_d    = wait_cnt;
    job_ack_d     = job_ack;
    div_a_d       = div_a;
    div_a_stb_d   = div_a_stb;
    div_b_d       = div_b;
    div_b_stb_d   = div_b_stb;
    div_z_ack_d   = div_z_ack;
    div_rst_d     = 1'b0;          // pulse: high for the abort cycle only
    res_z_d       = res_z;
    res_flags_d   = res_flags;
    res_stb_d     = res_stb;
    ops_done_d    = ops_done;
    ops_timeout_d = ops_timeout;

    unique case (state)
      IDLE: begin
        job_ack_d = 1'b1;
        if (job_xfer) begin
          job_ack_d   = 1'b0;
          div_a_d     = job_a;
          div_b_d     = job_b;
          div_a_stb_d = 1'b1;
        end
      end

      SEND_A: begin
        if (a_xfer) begin
          div_a_stb_d = 1'b0;
          div_b_stb_d = 1'b1;
        end
      end

      SEND_B: begin
        if (b_xfer) begin
          div_b_stb_d = 1'b0;
          wait_cnt_d  = '0;
          div_z_ack_d = 1'b1;
        end
      end

      WAIT_Z: begin
        if (z_xfer) begin
          div_z_ack_d = 1'b0;
          res_z_d     = div_z;
          res_flags_d = classify(div_z);
          res_stb_d   = 1'b1;
        end else if (timeout_hit) begin
          wait_cnt_d  = wait_cnt + 1'b1;
          div_z_ack_d = 1'b0;
          div_rst_d   = 1'b1;
          res_z_d     = QNAN;
          res_flags_d = 4'b1100;
          res_stb_d   = 1'b1;
          if (ops_timeout != 8'hFF) ops_timeout_d = ops_timeout + 8'd1;
        end else begin
          wait_cnt_d  = wait_cnt + 1'b1;
        end
      end

      PUT_RES: begin
        if (res_xfer) begin
          res_stb_d  = 1'b0;
          ops_done_d = ops_done + 16'd1;
          job_ack_d  = 1'b1;
        end
      end

      default: begin
        job_ack_d   = 1'b0;
        div_a_stb_d = 1'b0;
        div_b_stb_d = 1'b0;
        div_z_ack_d = 1'b0;
        res_stb_d   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fp_div_initiator.sv
// ---------------------------------------------------------------------------
// tb_fp_div_initiator
//
// Directed bench for fp_div_initiator. The stimulus tasks play both the job
// source and the divider, and push the hand-computed expected result of each
// job into a queue. An independent monitor pops that queue whenever a result
// transfer is about to happen and compares res_z / res_flags.
//
// Timing: the clock rises at 5 mod 10. Driver code samples and drives one
// time unit after the falling edge; the monitor samples three units after
// the falling edge, well clear of the rising edge.
// ---------------------------------------------------------------------------
module tb_fp_div_initiator;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] job_a = '0;
  logic [31:0] job_b = '0;
  logic        job_stb = 1'b0;
  logic        job_ack;
  logic [31:0] div_a;
  logic        div_a_stb;
  logic        div_a_ack = 1'b0;
  logic [31:0] div_b;
  logic        div_b_stb;
  logic        div_b_ack = 1'b0;
  logic [31:0] div_z = '0;
  logic        div_z_stb = 1'b0;
  logic        div_z_ack;
  logic        div_rst;
  logic [31:0] res_z;
  logic [3:0]  res_flags;
  logic        res_stb;
  logic        res_ack = 1'b0;
  logic [15:0] ops_done;
  logic [7:0]  ops_timeout;

  fp_div_initiator #(.TIMEOUT(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .job_a      (job_a),
    .job_b      (job_b),
    .job_stb    (job_stb),
    .job_ack    (job_ack),
    .div_a      (div_a),
    .div_a_stb  (div_a_stb),
    .div_a_ack  (div_a_ack),
    .div_b      (div_b),
    .div_b_stb  (div_b_stb),
    .div_b_ack  (div_b_ack),
    .div_z      (div_z),
    .div_z_stb  (div_z_stb),
    .div_z_ack  (div_z_ack),
    .div_rst    (div_rst),
    .res_z      (res_z),
    .res_flags  (res_flags),
    .res_stb    (res_stb),
    .res_ack    (res_ack),
    .ops_done   (ops_done),
    .ops_timeout(ops_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] z;
    logic [3:0]  f;
  } exp_t;

  exp_t exp_q[$];

  int errors   = 0;
  int checks   = 0;
  int exp_done = 0;
  int exp_to   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req,
               $time);
    end
  endtask

  // Advance to one unit after the next falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return job_ack;
      1:       return div_a_stb;
      2:       return div_b_stb;
      default: return res_stb;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input string name);
    for (int n = 0; n < 200; n++) begin
      if (sig(sel)) return;
      step();
    end
    check({name, "_wait_expired"}, 32'd0, 32'd1);
  endtask

  // Job handshake plus operand A and B transfers. Returns one step after the
  // div_b transfer edge.
  task automatic start_job(input logic [31:0] a, input logic [31:0] b,
                           input int a_dly);
    wait_sig(0, "job_ack");
    job_a   = a;
    job_b   = b;
    job_stb = 1'b1;
    step();
    check("job_ack_after_accept", 32'(job_ack), 32'd0);
    check("div_a_stb_set", 32'(div_a_stb), 32'd1);
    check("div_a_value", div_a, a);
    job_stb = 1'b0;
    job_a   = 32'hDEAD_BEEF;
    job_b   = 32'hDEAD_BEEF;
    for (int i = 0; i < a_dly; i++) begin
      div_z_stb = (i == 0);            // stray result outside WAIT_Z
      div_z     = 32'h3F80_0000;
      step();
      check("div_a_stable", div_a, a);
      check("div_a_stb_held", 32'(div_a_stb), 32'd1);
      check("div_z_ack_outside_wait", 32'(div_z_ack), 32'd0);
      check("job_ack_busy", 32'(job_ack), 32'd0);
    end
    div_z_stb = 1'b0;
    div_z     = '0;
    div_a_ack = 1'b1;
    step();
    check("div_a_stb_dropped", 32'(div_a_stb), 32'd0);
    check("div_b_stb_set", 32'(div_b_stb), 32'd1);
    check("div_b_value", div_b, b);
    div_a_ack = 1'b0;
    div_b_ack = 1'b1;
    step();
    check("div_b_stb_dropped", 32'(div_b_stb), 32'd0);
    check("div_z_ack_set", 32'(div_z_ack), 32'd1);
    div_b_ack = 1'b0;
  endtask

  // k = 0: divider never answers (timeout expected); otherwise the divider
  // result transfers on the k-th rising edge after the div_b transfer.
  task automatic run_job(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] z, input int k, input int a_dly,
                         input int r_dly, input logic [3:0] flags);
    exp_t e;
    e.z = (k == 0) ? 32'h7FC0_0000 : z;
    e.f = (k == 0) ? 4'b1100 : flags;
    exp_q.push_back(e);
    start_job(a, b, a_dly);
    if (k == 0) begin
      int n = 1;
      while (!div_rst && n < T + 10) begin
        step();
        n++;
      end
      check("timeout_latency", 32'(n), 32'(T + 1));
      check("timeout_div_z_ack", 32'(div_z_ack), 32'd0);
      check("timeout_res_stb", 32'(res_stb), 32'd1);
      step();
      check("div_rst_one_cycle", 32'(div_rst), 32'd0);
    end else begin
      repeat (k - 1) step();
      check("div_z_ack_waiting", 32'(div_z_ack), 32'd1);
      div_z     = z;
      div_z_stb = 1'b1;
      step();
      check("div_z_ack_dropped", 32'(div_z_ack), 32'd0);
      check("res_stb_set", 32'(res_stb), 32'd1);
      div_z_stb = 1'b0;
      div_z     = '0;
    end
    wait_sig(3, "res_stb");
    for (int i = 0; i < r_dly; i++) begin
      step();
      check("res_stb_held", 32'(res_stb), 32'd1);
      check("res_z_stable", res_z, e.z);
      check("res_flags_stable", 32'(res_flags), 32'(e.f));
      check("job_ack_while_res", 32'(job_ack), 32'd0);
    end
    res_ack = 1'b1;
    step();
    check("res_stb_dropped", 32'(res_stb), 32'd0);
    check("job_ack_after_res", 32'(job_ack), 32'd1);
    res_ack  = 1'b0;
    exp_done = (exp_done + 1) & 32'hFFFF;
    if (k == 0 && exp_to < 255) exp_to++;
    check("ops_done", 32'(ops_done), 32'(exp_done));
    check("ops_timeout", 32'(ops_timeout), 32'(exp_to));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_job_ack"},     32'(job_ack), 32'd0);
    check({tag, "_div_a_stb"},   32'(div_a_stb), 32'd0);
    check({tag, "_div_b_stb"},   32'(div_b_stb), 32'd0);
    check({tag, "_div_z_ack"},   32'(div_z_ack), 32'd0);
    check({tag, "_div_rst"},     32'(div_rst), 32'd0);
    check({tag, "_res_stb"},     32'(res_stb), 32'd0);
    check({tag, "_res_z"},       res_z, 32'd0);
    check({tag, "_res_flags"},   32'(res_flags), 32'd0);
    check({tag, "_div_a"},       div_a, 32'd0);
    check({tag, "_div_b"},       div_b, 32'd0);
    check({tag, "_ops_done"},    32'(ops_done), 32'd0);
    check({tag, "_ops_timeout"}, 32'(ops_timeout), 32'd0);
  endtask

  // Scoreboard monitor: compares every result transfer against the queue.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (res_stb && res_ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_res_z", res_z, e.z);
          check("sb_res_flags", 32'(res_flags), 32'(e.f));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and release.
    repeat (3) step();
    check_reset_state("reset");
    rst = 1'b0;
    step();
    check("job_ack_after_release", 32'(job_ack), 32'd1);

    // Normal results and flag classification.
    run_job(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1, 0, 0, 4'b0000);
    run_job(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 3, 0, 0, 4'b0010);
    run_job(32'h3F80_0000, 32'h0000_0000, 32'h7FC0_0000, 2, 0, 0, 4'b0100);
    run_job(32'h0000_0000, 32'h3F80_0000, 32'h8000_0000, 1, 0, 0, 4'b0001);
    run_job(32'h0000_0001, 32'h3F80_0000, 32'h0000_0001, 4, 0, 0, 4'b0000);
    run_job(32'hFF80_0001, 32'h3F80_0000, 32'hFF80_0001, 1, 0, 0, 4'b0100);

    // Slow peers: operand A ack after 5 cycles, result ack after 10.
    run_job(32'h4120_0000, 32'h4000_0000, 32'h40A0_0000, 2, 5, 10, 4'b0000);

    // Timeout, then a result arriving exactly on the timeout edge.
    run_job(32'h4040_0000, 32'h0000_0000, 32'h0, 0, 0, 2, 4'b1100);
    run_job(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, T, 0, 0, 4'b0000);

    // Reset while waiting for the divider: job dropped, no result.
    start_job(32'h4080_0000, 32'h4000_0000, 0);
    repeat (3) step();
    rst = 1'b1;
    step();
    check_reset_state("midreset");
    rst = 1'b0;
    step();
    check("job_ack_after_midreset", 32'(job_ack), 32'd1);
    check("res_stb_after_midreset", 32'(res_stb), 32'd0);
    exp_done = 0;
    exp_to   = 0;

    // 256 forced timeouts: counter saturates at 255.
    for (int i = 0; i < 256; i++)
      run_job(32'h4000_0000 + i, 32'h3F80_0000, 32'h0, 0, 0, 0, 4'b1100);
    check("ops_timeout_saturated", 32'(ops_timeout), 32'd255);

    repeat (5) step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
